// File: rtl/des_pkg.sv
// Shared DES definitions for the time-multiplexed S-box datapath.
// Holds the sequencer state enum, the fixed S-box geometry, the eight
// S-box tables and a lookup helper that applies the standard DES
// row/column indexing. Imported by sbox_bank and sbox_sequencer.
package des_pkg;

  localparam int SBOX_COUNT = 8;
  localparam int SBOX_AW    = 6;
  localparam int SBOX_DW    = 4;
  localparam int SBOX_IN_W  = 48;
  localparam int SBOX_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Each entry is one S-box row of 16 nibbles, column 0 in the top nibble.
  localparam logic [0:7][0:3][63:0] SBOX_TBL = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A628E5CBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Row = {addr[5], addr[0]}, col = addr[4:1].
  function automatic logic [SBOX_DW-1:0] sbox_lookup(input logic [2:0] box,
                                                     input logic [SBOX_AW-1:0] addr);
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] row_word;
    row      = {addr[5], addr[0]};
    col      = addr[4:1];
    row_word = SBOX_TBL[box][row] << {col, 2'b00};
    return row_word[63:60];
  endfunction

endpackage

// File: rtl/sbox_bank.sv
// Combinational bank of the eight DES S-box ROMs on one shared address.
// Ports:
//   addr  in  6  shared 6-bit S-box input chunk
//   sel   in  3  box select (0 = S1 ... 7 = S8)
//   data  out 4  output of the selected box
module sbox_bank
  import des_pkg::*;
(
  input  logic [SBOX_AW-1:0] addr,
  input  logic [2:0]         sel,
  output logic [SBOX_DW-1:0] data
);

  logic [SBOX_DW-1:0] box_out [SBOX_COUNT];

  for (genvar b = 0; b < SBOX_COUNT; b++) begin : g_rom
    assign box_out[b] = sbox_lookup(3'(b), addr);
  end

  assign data = box_out[sel];

endmodule

// File: rtl/sbox_sequencer.sv
// Time-multiplexed DES S-box substitution controller. Accepts one 48-bit
// key-mixed word, looks up S1..S8 one chunk per cycle through a shared
// sbox_bank, and presents the assembled 32-bit result until it is taken.
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high; the producer holds data stable while valid is high and
// ready is low, and valid never waits on ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, din sampled on the accept edge
//   din       [47:0]     key-mixed word, [47:42] -> S1 ... [5:0] -> S8
//   abort                synchronous flush to IDLE, drops any result
//   out_valid/out_ready  output handshake
//   dout      [31:0]     S1 result in [31:28] ... S8 result in [3:0]
//   busy                 high while the lookups are running
module sbox_sequencer
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SBOX_IN_W-1:0]  din,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SBOX_OUT_W-1:0] dout,
  output logic                  busy
);

  seq_state_e            state_q, state_d;
  logic [SBOX_IN_W-1:0]  sreg;
  logic [2:0]            cnt;
  logic [SBOX_OUT_W-1:0] acc;
  logic [SBOX_DW-1:0]    rom_out;
  logic                  load, step, clear;

  sbox_bank u_bank (
    .addr (sreg[SBOX_IN_W-1 -: SBOX_AW]),
    .sel  (cnt),
    .data (rom_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == 3'd7) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort overrides any accept, lookup step or output handshake
    if (abort) begin
      state_d = IDLE;
      load    = 1'b0;
      step    = 1'b0;
      clear   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
      acc  <= '0;
    end else if (step) begin
      acc  <= {acc[SBOX_OUT_W-SBOX_DW-1:0], rom_out};
      sreg <= sreg << SBOX_AW;
      cnt  <= cnt + 3'd1;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign dout      = acc;

endmodule

// File: tb/tb_sbox_sequencer.sv
module tb_sbox_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] din;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[6];

  sbox_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic accept_word(input logic [47:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    din      = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = $urandom_range(0, 32'hFFFF_FFFF);
    check("accept_busy", {in_ready, busy}, 2'b01);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vector(input string name, input logic [47:0] w, input logic [31:0] e);
    int lat;
    exp_q.push_back(e);
    accept_word(w);
    wait_done(lat);
    check({name, "_latency"}, lat, 8);
    check({name, "_dout"}, dout, exp_q.pop_front());
    @(posedge clk);
    #1;
    check({name, "_release"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{48'h000000080000, 32'hEFA7CC4D};
    vecs[3] = '{48'h000000000001, 32'hEFA72C41};
    vecs[4] = '{48'h800000000000, 32'h4FA72C4D};
    vecs[5] = '{48'h040000000000, 32'h0FA72C4D};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_outputs", {in_ready, out_valid, busy}, 3'b100);
    check("reset_dout", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 6; i++) run_vector($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);

    // backpressure: DONE held 20 cycles, new word not accepted
    out_ready = 1'b0;
    accept_word(48'h0);
    wait_done(lat);
    check("bp_latency", lat, 8);
    held = 32'hEFA72C4D;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = 48'hFFFFFFFFFFFF;
      @(posedge clk);
      #1;
      check("bp_hold", {in_ready, out_valid, busy, dout}, {3'b010, held});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {in_ready, out_valid, busy}, 3'b100);

    // abort in IDLE with in_valid high: no accept
    @(negedge clk);
    in_valid = 1'b1;
    abort    = 1'b1;
    din      = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_idle", {in_ready, busy}, 2'b10);

    // abort at RUN cycle 4
    accept_word(48'hFFFFFFFFFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_run_state", {in_ready, out_valid, busy}, 3'b100);
    check("abort_run_dout", dout, 32'h0);
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("abort_no_output", lat, 0);
    run_vector("post_abort", 48'h0, 32'hEFA72C4D);

    // asynchronous reset at RUN cycle 3
    accept_word(48'hFFFFFFFFFFFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {in_ready, out_valid, busy}, 3'b100);
    check("async_rst_dout", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vector("post_reset", 48'h000000080000, 32'hEFA7CC4D);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
